im_access_arbiter: RTL and testbench

Shares the single-port 64K x 16 instruction memory between the CPU fetch port (read-only) and the debug/bootloader port (read/write, driven by the UART/SPART loader).
- Holds the CPU off in BOOT mode while the loader fills memory.
- In RUN mode, CPU fetch has priority; a starvation limit guarantees debug progress.
- Sits between the fetch stage and the instruction memory; the memory is the write-capable variant.

---
 rtl/im_arb_pkg.sv | 14 +
 rtl/im_starve_cnt.sv | 30 +++
 rtl/im_access_arbiter.sv | 116 +++++++++++
 tb/tb_im_access_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_arb_pkg.sv
// Shared types and defaults for the instruction-memory access arbiter.
package im_arb_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/im_starve_cnt.sv
// Saturating count of consecutive denied debug cycles; at_limit forces a debug grant.
module im_starve_cnt
  import im_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/im_access_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch and the debug/boot loader.
module im_access_arbiter
  import im_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_en,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_vld,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mode_run
);

  arb_state_e state, state_next;
  logic       dbg_busy;
  logic       dbg_grant;
  logic       cpu_grant;
  logic       starve_at_limit;
  logic       starve_inc;
  logic       starve_clr;

  // dbg_busy marks the ack cycle of a debug access; it blocks re-grant and mode changes.
  always_comb begin
    state_next = state;
    dbg_grant  = 1'b0;
    cpu_grant  = 1'b0;
    cpu_stall  = cpu_req;
    case (state)
      BOOT: begin
        dbg_grant = dbg_req && !dbg_busy;
        cpu_stall = 1'b1;
        if (!boot_en && !dbg_busy) state_next = RUN;
      end
      RUN: begin
        if (dbg_req && !dbg_busy && (starve_at_limit || !cpu_req)) begin
          dbg_grant = 1'b1;
        end else if (cpu_req) begin
          cpu_grant = 1'b1;
        end
        cpu_stall = cpu_req && !cpu_grant;
        if (boot_en) state_next = DRAIN;
      end
      DRAIN: begin
        if (!dbg_busy) state_next = BOOT;
      end
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (dbg_grant) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_rd_en = !dbg_we;
      mem_wdata = dbg_we ? dbg_wdata : '0;
    end else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_rd_en = 1'b1;
    end
  end

  assign starve_inc = (state == RUN) && dbg_req && !dbg_busy && !dbg_grant;
  assign starve_clr = (state != RUN) || !dbg_req || dbg_grant;

  im_starve_cnt #(
    .LIMIT(STARVE_LIM)
  ) u_starve_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(starve_at_limit)
  );

  // Read data is captured at the end of the grant cycle, so valid/ack land one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= BOOT;
      dbg_busy  <= 1'b0;
      cpu_vld   <= 1'b0;
      cpu_instr <= '0;
      dbg_rdata <= '0;
    end else begin
      state    <= state_next;
      dbg_busy <= dbg_grant;
      cpu_vld  <= cpu_grant;
      if (cpu_grant) cpu_instr <= mem_rdata;
      if (dbg_grant && !dbg_we) dbg_rdata <= mem_rdata;
    end
  end

  assign dbg_ack  = dbg_busy;
  assign mode_run = (state == RUN);

endmodule

// File: tb/tb_im_access_arbiter.sv
// Self-checking bench: directed vectors plus a short random phase, checked every cycle by a mode-level model.
module tb_im_access_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_en;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_instr;
  logic        cpu_vld;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_wdata;
  logic [15:0] dbg_rdata;
  logic        dbg_ack;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mode_run;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] dev_mem [0:65535];
  logic [15:0] ref_mem [0:65535];

  im_access_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_LIM(LIM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .boot_en  (boot_en),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_instr(cpu_instr),
    .cpu_vld  (cpu_vld),
    .cpu_stall(cpu_stall),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata),
    .dbg_ack  (dbg_ack),
    .mem_addr (mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mode_run (mode_run)
  );

  always #5 clk = ~clk;

  // Memory device: combinational read, write committed at the clock edge.
  assign mem_rdata = dev_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) dev_mem[mem_addr] = mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic b, input logic cr, input logic [15:0] ca,
                               input logic dr, input logic dw, input logic [15:0] da,
                               input logic [15:0] dd);
    @(posedge clk);
    #1;
    rst_n     = r;
    boot_en   = b;
    cpu_req   = cr;
    cpu_addr  = ca;
    dbg_req   = dr;
    dbg_we    = dw;
    dbg_addr  = da;
    dbg_wdata = dd;
    @(negedge clk);
  endtask

  // Mode-level model: 0 = loader owns memory, 1 = running, 2 = draining back to loader.
  int          m_mode  = 0;
  int          m_denied = 0;
  bit          m_ack_due = 0;
  bit          m_valid = 0;
  bit          m_cpu_vld = 0;
  logic [15:0] m_cpu_instr = 16'h0;
  logic [15:0] m_dbg_rdata = 16'h0;
  bit          e_dbg;
  bit          e_cpu;
  bit          e_stall;
  logic [15:0] e_addr;

  always @(negedge clk) begin
    e_dbg = 0;
    e_cpu = 0;
    if (m_mode == 0) begin
      e_dbg   = dbg_req && !m_ack_due;
      e_stall = 1;
    end else if (m_mode == 1) begin
      if (dbg_req && !m_ack_due && (m_denied >= LIM || !cpu_req)) e_dbg = 1;
      else if (cpu_req) e_cpu = 1;
      e_stall = cpu_req && !e_cpu;
    end else begin
      e_stall = cpu_req;
    end
    e_addr = e_dbg ? dbg_addr : (e_cpu ? cpu_addr : 16'h0);

    if (m_valid) begin
      checkOutput("cpu_vld", {31'b0, cpu_vld}, {31'b0, m_cpu_vld});
      checkOutput("cpu_instr", {16'b0, cpu_instr}, {16'b0, m_cpu_instr});
      checkOutput("dbg_ack", {31'b0, dbg_ack}, {31'b0, m_ack_due});
      checkOutput("dbg_rdata", {16'b0, dbg_rdata}, {16'b0, m_dbg_rdata});
      checkOutput("mode_run", {31'b0, mode_run}, (m_mode == 1) ? 32'd1 : 32'd0);
      checkOutput("cpu_stall", {31'b0, cpu_stall}, {31'b0, e_stall});
      checkOutput("mem_addr", {16'b0, mem_addr}, {16'b0, e_addr});
      checkOutput("mem_we", {31'b0, mem_we}, {31'b0, e_dbg && dbg_we});
      checkOutput("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, e_cpu || (e_dbg && !dbg_we)});
      checkOutput("mem_wdata", {16'b0, mem_wdata}, (e_dbg && dbg_we) ? {16'b0, dbg_wdata} : 32'd0);
    end

    if (!rst_n) begin
      m_mode      = 0;
      m_denied    = 0;
      m_ack_due   = 0;
      m_cpu_vld   = 0;
      m_cpu_instr = 16'h0;
      m_dbg_rdata = 16'h0;
      m_valid     = 1;
    end else begin
      m_cpu_vld = e_cpu;
      if (e_cpu) m_cpu_instr = ref_mem[cpu_addr];
      if (e_dbg && !dbg_we) m_dbg_rdata = ref_mem[dbg_addr];
      if (e_dbg && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      if (m_mode != 1 || !dbg_req || e_dbg) m_denied = 0;
      else if (!m_ack_due && m_denied < LIM) m_denied = m_denied + 1;
      if (m_mode == 0 && !boot_en && !m_ack_due) m_mode = 1;
      else if (m_mode == 1 && boot_en) m_mode = 2;
      else if (m_mode == 2 && !m_ack_due) m_mode = 0;
      m_ack_due = e_dbg;
    end
  end

  logic        r_dr = 0;
  logic        r_dw = 0;
  logic [15:0] r_da = 16'h0;
  logic [15:0] r_dd = 16'h0;
  logic        r_boot = 0;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    rst_n = 0; boot_en = 0; cpu_req = 0; cpu_addr = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    applyStimulus(0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);

    // Loader write in BOOT while the CPU is asking
    applyStimulus(1, 1, 1, 16'h0010, 1, 1, 16'h0010, 16'hBEEF);
    checkOutput("rst_mode_run", {31'b0, mode_run}, 32'd0);
    checkOutput("rst_cpu_vld", {31'b0, cpu_vld}, 32'd0);
    checkOutput("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    checkOutput("rst_cpu_instr", {16'b0, cpu_instr}, 32'h0);
    checkOutput("rst_dbg_rdata", {16'b0, dbg_rdata}, 32'h0);
    checkOutput("boot_wr_we", {31'b0, mem_we}, 32'd1);
    checkOutput("boot_wr_addr", {16'b0, mem_addr}, 32'h0010);
    checkOutput("boot_wr_data", {16'b0, mem_wdata}, 32'hBEEF);
    checkOutput("boot_stall", {31'b0, cpu_stall}, 32'd1);
    applyStimulus(1, 1, 1, 16'h0010, 1, 1, 16'h0010, 16'hBEEF);
    checkOutput("boot_wr_ack", {31'b0, dbg_ack}, 32'd1);
    checkOutput("boot_no_regrant", {31'b0, mem_we}, 32'd0);
    checkOutput("boot_stall_ack", {31'b0, cpu_stall}, 32'd1);
    checkOutput("boot_no_vld", {31'b0, cpu_vld}, 32'd0);
    checkOutput("boot_wr_rdata_kept", {16'b0, dbg_rdata}, 32'h0);

    // Leave BOOT and fetch the loaded word
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    checkOutput("still_boot", {31'b0, mode_run}, 32'd0);
    applyStimulus(1, 0, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    checkOutput("run_entered", {31'b0, mode_run}, 32'd1);
    checkOutput("run_fetch_stall", {31'b0, cpu_stall}, 32'd0);
    checkOutput("run_fetch_addr", {16'b0, mem_addr}, 32'h0010);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    checkOutput("run_fetch_vld", {31'b0, cpu_vld}, 32'd1);
    checkOutput("run_fetch_instr", {16'b0, cpu_instr}, 32'hBEEF);

    // Starvation: CPU wins four cycles, debug forced on the fifth
    for (int i = 0; i < LIM; i++) begin
      applyStimulus(1, 0, 1, 16'h0020, 1, 0, 16'h0010, 16'h0);
      checkOutput("starve_cpu_wins", {16'b0, mem_addr}, 32'h0020);
    end
    applyStimulus(1, 0, 1, 16'h0020, 1, 0, 16'h0010, 16'h0);
    checkOutput("starve_forced_addr", {16'b0, mem_addr}, 32'h0010);
    checkOutput("starve_forced_stall", {31'b0, cpu_stall}, 32'd1);
    applyStimulus(1, 0, 1, 16'h0020, 1, 0, 16'h0010, 16'h0);
    checkOutput("starve_ack", {31'b0, dbg_ack}, 32'd1);
    checkOutput("starve_rdata", {16'b0, dbg_rdata}, 32'hBEEF);
    checkOutput("starve_ack_stall", {31'b0, cpu_stall}, 32'd0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    checkOutput("starve_cpu_instr", {16'b0, cpu_instr}, 32'h5A7A);

    // Idle CPU: debug read granted at once, no re-grant in the ack cycle
    applyStimulus(1, 0, 0, 16'h0, 1, 0, 16'h0030, 16'h0);
    checkOutput("idle_dbg_rd_en", {31'b0, mem_rd_en}, 32'd1);
    checkOutput("idle_dbg_addr", {16'b0, mem_addr}, 32'h0030);
    applyStimulus(1, 0, 0, 16'h0, 1, 0, 16'h0030, 16'h0);
    checkOutput("idle_dbg_ack", {31'b0, dbg_ack}, 32'd1);
    checkOutput("idle_dbg_rdata", {16'b0, dbg_rdata}, 32'h5A6A);
    checkOutput("idle_no_regrant", {31'b0, mem_rd_en}, 32'd0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    checkOutput("idle_ack_once", {31'b0, dbg_ack}, 32'd0);

    // boot_en rises in the cycle of a debug grant
    applyStimulus(1, 1, 0, 16'h0, 1, 0, 16'h0010, 16'h0);
    checkOutput("drain_grant", {31'b0, mem_rd_en}, 32'd1);
    applyStimulus(1, 1, 1, 16'h0010, 1, 0, 16'h0010, 16'h0);
    checkOutput("drain_mode", {31'b0, mode_run}, 32'd0);
    checkOutput("drain_ack", {31'b0, dbg_ack}, 32'd1);
    checkOutput("drain_rdata", {16'b0, dbg_rdata}, 32'hBEEF);
    checkOutput("drain_cpu_held", {31'b0, cpu_stall}, 32'd1);
    checkOutput("drain_no_grant", {31'b0, mem_rd_en}, 32'd0);
    applyStimulus(1, 1, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    checkOutput("drain_cpu_held2", {31'b0, cpu_stall}, 32'd1);
    applyStimulus(1, 1, 1, 16'h0010, 1, 1, 16'h0040, 16'h1234);
    checkOutput("reboot_wr_we", {31'b0, mem_we}, 32'd1);
    checkOutput("reboot_wr_addr", {16'b0, mem_addr}, 32'h0040);
    applyStimulus(1, 1, 1, 16'h0010, 1, 1, 16'h0040, 16'h1234);
    checkOutput("reboot_wr_ack", {31'b0, dbg_ack}, 32'd1);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);

    // Reset lands on a CPU grant: the fetch is lost
    applyStimulus(0, 0, 1, 16'h0040, 0, 0, 16'h0, 16'h0);
    checkOutput("rst_mid_grant", {31'b0, mem_rd_en}, 32'd1);
    applyStimulus(1, 0, 1, 16'h0040, 0, 0, 16'h0, 16'h0);
    checkOutput("rst_mid_vld", {31'b0, cpu_vld}, 32'd0);
    checkOutput("rst_mid_mode", {31'b0, mode_run}, 32'd0);
    checkOutput("rst_mid_rd_en", {31'b0, mem_rd_en}, 32'd0);
    checkOutput("rst_mid_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mid_stall", {31'b0, cpu_stall}, 32'd1);
    applyStimulus(1, 0, 1, 16'h0040, 0, 0, 16'h0, 16'h0);
    checkOutput("rst_rerun", {31'b0, mode_run}, 32'd1);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    checkOutput("rst_refetch", {16'b0, cpu_instr}, 32'h1234);

    // Random traffic with a well-behaved debug requester, checked by the model
    for (int i = 0; i < 400; i++) begin
      if (r_dr && dbg_ack) begin
        r_dr = 0;
      end else if (!r_dr && ($urandom_range(0, 2) == 0)) begin
        r_dr = 1;
        r_dw = 1'($urandom_range(0, 1));
        r_da = {12'h000, 4'($urandom_range(0, 15))};
        r_dd = 16'($urandom);
      end
      if ($urandom_range(0, 29) == 0) r_boot = !r_boot;
      applyStimulus(1, r_boot, ($urandom_range(0, 3) != 0), {12'h000, 4'($urandom_range(0, 15))},
                    r_dr, r_dw, r_da, r_dd);
    end
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
